// File: rtl/write_address_generator_if.sv
// Handshake and address bus between the write-address generator and its row source.
// The master modport is the row source; the slave modport is the generator.
interface write_address_generator_if #(
  parameter int unsigned SIZE   = 257,
  parameter int unsigned ADDR_W = 8
);
  logic                         start;
  logic                         mode;
  logic                         in_valid;
  logic                         we;
  logic [SIZE-1:0][ADDR_W-1:0]  addr;
  logic                         busy;
  logic                         done;

  modport master (
    output start, mode, in_valid,
    input  we, addr, busy, done
  );

  modport slave (
    input  start, mode, in_valid,
    output we, addr, busy, done
  );
endinterface

// File: rtl/write_address_generator.sv
// Per-bank write address generator for returning NTT result rows: linear (mode 0) or
// lane-rotated (mode 1) address vectors, one pass of DEPTH accepted rows per start.
module write_address_generator #(
  parameter int unsigned SIZE   = 257,
  parameter int unsigned DEPTH  = 85,
  parameter int unsigned ROT    = 2,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  write_address_generator_if.slave        bus_io
);

  localparam int unsigned BeatW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(DEPTH - 1);

  typedef logic [SIZE-1:0][ADDR_W-1:0] addr_vec_t;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [BeatW-1:0] beat_q, beat_d;
  addr_vec_t        addr_q, addr_d;
  logic             done_q, done_d;

  addr_vec_t        init_rot;
  addr_vec_t        rot_next;
  addr_vec_t        inc_next;

  // Lane permutation and start offsets are fixed at elaboration; no runtime modulo.
  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    localparam int unsigned Src = (g + ROT) % SIZE;
    localparam logic [ADDR_W-1:0] Init = ADDR_W'(g % DEPTH);

    assign init_rot[g] = Init;
    assign rot_next[g] = addr_q[Src];
    assign inc_next[g] = (addr_q[g] == ADDR_W'(DEPTH - 1)) ? '0 : addr_q[g] + ADDR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StRun;
          mode_d  = bus_io.mode;
          beat_d  = '0;
          addr_d  = bus_io.mode ? init_rot : '0;
        end
      end
      StRun: begin
        if (bus_io.in_valid) begin
          if (beat_q == LastBeat) begin
            // Last row keeps its addresses visible until the next start.
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + BeatW'(1);
            addr_d = mode_q ? rot_next : inc_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      beat_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  assign bus_io.we   = (state_q == StRun) && bus_io.in_valid;
  assign bus_io.busy = (state_q == StRun);
  assign bus_io.done = done_q;
  assign bus_io.addr = addr_q;

endmodule

// File: doc/write_address_generator.md
# write_address_generator

Write-side counterpart of the bank read-address generator in the non-power-of-two NTT datapath. It produces per-bank write addresses and a write enable for the 257 coefficient banks while result rows return from the butterfly pipeline. Each accepted row advances the addresses. Mode 0 writes every bank at the same row index; mode 1 rotates the per-bank address vector in the direction opposite to the read side, so transposed data lands in its destination banks. A pass covers DEPTH rows and ends with a one-cycle `done` pulse.

## Interface
- `SIZE`, 257, number of banks (lanes per row)
- `DEPTH`, 85, rows per bank; pass length in beats
- `ROT`, 2, lane rotation per beat in mode 1
- `ADDR_W`, 8, address width; must satisfy 2^ADDR_W ≥ DEPTH
- `clk`  in  1  sole clock; all state changes on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse that begins a pass; honoured only in IDLE
- `mode`  in  1  pass mode, sampled with `start`; 0 = linear, 1 = rotated
- `in_valid`  in  1  a result row is present on the bank write data bus this cycle
- `we`  out  1  bank write enable, `in_valid` gated by state RUN (combinational)
- `addr`  out  [SIZE-1:0][ADDR_W-1:0]  registered per-bank write address
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle pulse after the last row is accepted

## Operation
- States: IDLE, RUN. Internal registers: `mode_q`, `beat` (0..DEPTH-1), `addr_reg[SIZE]`.
- IDLE with `start`=1:
  - latch `mode_q`=`mode`, set `beat`=0, go to RUN.
  - Load `addr_reg[i]` = 0 if `mode`=0, else `i % DEPTH`.
- IDLE with `start`=0: hold all state; `we`=0 regardless of `in_valid`.
- RUN: `we` = `in_valid`. A beat is accepted when `in_valid`=1; no backpressure, every valid row is written.
- On an accepted beat with `beat` < DEPTH-1:
  - `beat`+1.
  - Mode 0: `addr_reg[i]` = (`addr_reg[i]`+1) mod DEPTH.
  - Mode 1: `addr_reg[i]` = `addr_reg[(i+ROT) % SIZE]`, a left rotation of the lane vector.
- On an accepted beat with `beat` = DEPTH-1:
  - go to IDLE; assert `done` next cycle.
  - `addr_reg` is NOT advanced; it holds the last-row addresses until the next `start`.
- RUN with `in_valid`=0: hold everything.
- `start` while in RUN: ignored, with no effect on `mode_q`, `beat` or `addr_reg`.
- `mode` changes during RUN: ignored, since only `mode_q` is used.
- Arithmetic:
  - Mode-0 increment wraps DEPTH-1 → 0 without overflowing ADDR_W.
  - `i % DEPTH` and `(i+ROT) % SIZE` are elaboration-time constants; no runtime divider.

## Timing
- Reset (`reset_n`=0, asynchronous):
  - state IDLE, `beat`=0, `mode_q`=0, every `addr[i]`=0.
  - `busy`=0, `done`=0, `we`=0.
- Reset asserted mid-pass aborts immediately. No `done` is produced. The next pass requires a new `start`.
- `start` sampled at edge t: `busy`=1 and `addr` = initial vector from t+1. The first row may be accepted in cycle t+1.
- `addr` in a cycle is the address for the row presented that same cycle. The update after acceptance appears the following cycle (zero-cycle write latency from `in_valid` to `we`).
- Last beat accepted at edge t: `busy`=0 and `done`=1 for the cycle after t; `done`=0 afterwards.
- `start` asserted in the `done` cycle is honoured, since state is already IDLE. Back-to-back passes need no gap cycle.
- Minimum pass length: DEPTH+1 cycles from `start` to `done` with `in_valid` held high.

## Test plan
- Reset, then mode 0 `start`, `in_valid` high continuously:
  - every `addr[i]`=k on beat k (k=0..84).
  - `we` high for 85 cycles.
  - `done` pulses exactly once, one cycle after beat 84; `addr` then holds 84.
- Mode 1 `start`:
  - beat 0: `addr[0]`=0, `addr[100]`=15, `addr[256]`=1.
  - after one accepted beat: `addr[0]`=2, `addr[100]`=17, `addr[255]`=0, `addr[256]`=1.
- Mode 0 with `in_valid` toggling 1,0,0,1:
  - `addr` advances only on valid cycles.
  - `we` mirrors `in_valid`; `done` arrives after the 85th valid beat.
- `in_valid` and `start` in IDLE:
  - `in_valid` before `start` gives `we`=0.
  - `start` pulsed at beat 40 of a mode-0 pass: addresses continue 41, 42, … and `mode_q` is unchanged.
- `reset_n` low at beat 50: asynchronous clear of `addr` to 0 and `busy` to 0, with no `done`. A following mode-1 pass starts from `addr[i]` = `i % 85`.
- `start` in the `done` cycle: new pass begins with `busy`=1 on the next cycle and `addr` reloaded.
